alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Upstream command stage for the 8-bit, 4-op ALU (add/sub/mul/div, 16-bit result).
- Accepts one operation per valid/ready handshake, registers it onto the ALU operand/select inputs, and waits a fixed settle latency.
- Captures the ALU result and presents it on a valid/ready result port with an error flag.
- Intercepts divide-by-zero so the ALU result is never consumed for that case.

Parameters:
- DW, 8, operand width; result width is 2*DW.
- ALU_LAT, 1, clock edges between driving the ALU inputs and sampling alu_z (legal range 1..15).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_sel  in  2  0=add, 1=sub, 2=mul, 3=div.
- cmd_a  in  DW  operand A.
- cmd_b  in  DW  operand B.
- alu_a  out  DW  registered operand to ALU A.
- alu_b  out  DW  registered operand to ALU B.
- alu_sel  out  2  registered select to ALU Sel.
- alu_z  in  2*DW  ALU result.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  2*DW  captured result.
- res_err  out  1  1 = divide-by-zero; res_data is all-ones.
- op_count  out  16  completed result handshakes, wraps at 16'hFFFF.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - All outputs 0, except cmd_ready=1 once out of reset (cmd_ready is a decode of IDLE).
  - Internal latency counter = 0.
  - Reset mid-operation drops the pending command and any unconsumed result silently.
- States:
  - IDLE: cmd_ready=1, res_valid=0. On cmd_valid at a rising edge:
    - Register cmd_a/cmd_b/cmd_sel into alu_a/alu_b/alu_sel.
    - If cmd_sel==3 and cmd_b==0: go to RESP with res_data={2*DW{1'b1}}, res_err=1.
    - Otherwise: go to WAIT, load counter=ALU_LAT-1, clear res_err.
  - WAIT: cmd_ready=0.
    - If counter!=0, decrement.
    - If counter==0, res_data<=alu_z and go to RESP.
    - Net effect: alu_z is sampled exactly ALU_LAT edges after the accept edge.
  - RESP: res_valid=1, cmd_ready=0. res_data and res_err are held stable while res_valid && !res_ready.
    - On res_ready: op_count<=op_count+1 (wraps 16'hFFFF->0) and go to IDLE.
    - res_valid falls the cycle after the handshake.
- Operand and result stability:
  - alu_a/alu_b/alu_sel change only on an accept edge; they hold the last command in every other state.
  - res_data/res_err hold their last values in IDLE and WAIT; only res_valid qualifies them.
- Width and arithmetic:
  - res_data is passed through from alu_z unmodified.
  - The sequencer performs no arithmetic except the divide-by-zero check (compare the full DW bits of cmd_b to 0).
- Throughput:
  - cmd_ready is asserted only in IDLE, so there is no accept on the same edge as a result handshake.
  - Minimum period is ALU_LAT+2 cycles per op (accept, ALU_LAT-1 wait edges, capture, handshake, return to IDLE).
  - Divide-by-zero ops take 2 cycles minimum.
- Simultaneous events:
  - cmd_valid outside IDLE is ignored and the command is not consumed.
  - res_ready outside RESP has no effect.
- No combinational path from any input to any output.
  - Exception: cmd_ready and res_valid are pure state decodes, which is permitted.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-WAIT -> immediately state=IDLE, res_valid=0, alu_a/alu_b/alu_sel=0, op_count=0; after release cmd_ready=1.
- Add, ALU_LAT=1, behavioural ALU model: cmd a=8'd200, b=8'd100, sel=0, res_ready held 1 -> alu_a=200 after accept edge; res_valid rises 1 edge later with res_data=16'd300, res_err=0; op_count=1; cmd_ready back to 1 the next cycle.
- Sub and mul back-to-back: a=3, b=5, sel=1 -> res_data=16'hFFFE; then a=255, b=255, sel=2 -> res_data=16'hFE01; op_count=2; second command is held off (cmd_ready=0) until the first handshake completes.
- Divide-by-zero: a=8'd9, b=0, sel=3 -> res_valid on the next edge with res_data=16'hFFFF and res_err=1. Follow with a=9, b=2, sel=3 -> res_data=16'd4, res_err=0.
- Backpressure with ALU_LAT=3: accept a=10, b=3, sel=2 -> res_valid exactly 3 edges later with res_data=16'd30; hold res_ready=0 for 5 cycles -> res_data/res_valid stable and cmd_valid ignored; raise res_ready -> handshake, op_count increments once.
- Wrap: force op_count to 16'hFFFF via 65535 ops (or a preload in the bench), complete one op -> op_count=16'h0000.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Command stage in front of an 8-bit, 4-op ALU (add/sub/mul/div, 2*DW-bit result).
//   It accepts one command per cmd_valid/cmd_ready handshake and registers the
//   operands and select onto the ALU inputs. It then waits ALU_LAT edges,
//   captures alu_z, and presents it on a res_valid/res_ready port.
//   Divide-by-zero is caught at accept time. It answers with all-ones data and
//   res_err=1 without ever consuming the ALU result.
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake; cmd_ready is a decode of IDLE
//   cmd_sel, cmd_a, cmd_b  0=add 1=sub 2=mul 3=div, operands
//   alu_a, alu_b, alu_sel  registered operands/select driven to the ALU
//   alu_z                  ALU result
//   res_valid/res_ready    result handshake; res_valid is a decode of RESP
//   res_data, res_err      captured result, divide-by-zero flag
//   op_count               completed result handshakes (wrapping)
module alu_op_sequencer #(
  parameter int DW      = 8,
  parameter int ALU_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_sel,
  input  logic [DW-1:0]   cmd_a,
  input  logic [DW-1:0]   cmd_b,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [1:0]      alu_sel,
  input  logic [2*DW-1:0] alu_z,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [2*DW-1:0] res_data,
  output logic            res_err,
  output logic [15:0]     op_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // The counter is loaded with ALU_LAT-1 on accept. WAIT then samples alu_z
  // on the edge where the counter is already zero, so the capture lands
  // exactly ALU_LAT edges after the accept edge.
  localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT - 1);

  state_t            state_reg, state_next;
  logic [3:0]        lat_cnt_reg;
  logic [DW-1:0]     alu_a_reg, alu_b_reg;
  logic [1:0]        alu_sel_reg;
  logic [2*DW-1:0]   res_data_reg;
  logic              res_err_reg;
  logic [15:0]       op_count_reg;

  logic accept;
  logic div_zero;
  logic res_hs;
  logic lat_done;

  assign accept   = (state_reg == ST_IDLE) && cmd_valid;
  assign div_zero = (cmd_sel == 2'd3) && (cmd_b == '0);
  assign res_hs   = (state_reg == ST_RESP) && res_ready;
  assign lat_done = (lat_cnt_reg == 4'd0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_next = div_zero ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_done) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (res_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, latency counter, result capture, op counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt_reg  <= 4'd0;
      alu_a_reg    <= '0;
      alu_b_reg    <= '0;
      alu_sel_reg  <= 2'd0;
      res_data_reg <= '0;
      res_err_reg  <= 1'b0;
      op_count_reg <= 16'd0;
    end else begin
      if (accept) begin
        alu_a_reg   <= cmd_a;
        alu_b_reg   <= cmd_b;
        alu_sel_reg <= cmd_sel;
        if (div_zero) begin
          // The ALU output is never sampled for this command.
          res_data_reg <= '1;
          res_err_reg  <= 1'b1;
        end else begin
          lat_cnt_reg <= LAT_LOAD;
          res_err_reg <= 1'b0;
        end
      end

      if (state_reg == ST_WAIT) begin
        if (lat_done) begin
          res_data_reg <= alu_z;
        end else begin
          lat_cnt_reg <= lat_cnt_reg - 4'd1;
        end
      end

      if (res_hs) begin
        op_count_reg <= op_count_reg + 16'd1;
      end
    end
  end

  assign cmd_ready = (state_reg == ST_IDLE);
  assign res_valid = (state_reg == ST_RESP);
  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_sel   = alu_sel_reg;
  assign res_data  = res_data_reg;
  assign res_err   = res_err_reg;
  assign op_count  = op_count_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer.
//   dut1: ALU_LAT=1 with a combinational ALU model.
//   dut3: ALU_LAT=3 with an ALU model whose result appears two register
//         stages after its inputs change.
// Expected results are pushed into a per-instance queue when a command is
// issued. A monitor per instance pops the queue and compares on every result
// handshake.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [1:0] s);
    case (s)
      2'd0:    return 16'(a) + 16'(b);
      2'd1:    return 16'(a) - 16'(b);
      2'd2:    return 16'(a) * 16'(b);
      default: return (b == 8'd0) ? 16'hDEAD : 16'(a / b);
    endcase
  endfunction

  // ---------------- dut1 (ALU_LAT=1) ----------------
  logic       cv1 = 1'b0, cr1, rv1, rr1 = 1'b1, re1;
  logic [1:0] cs1 = 2'd0, as1;
  logic [7:0] ca1 = 8'd0, cb1 = 8'd0, aa1, ab1;
  logic [15:0] z1, rd1, oc1;
  assign z1 = alu_f(aa1, ab1, as1);

  alu_op_sequencer #(.DW(8), .ALU_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cv1), .cmd_ready(cr1), .cmd_sel(cs1),
    .cmd_a(ca1), .cmd_b(cb1), .alu_a(aa1), .alu_b(ab1), .alu_sel(as1),
    .alu_z(z1), .res_valid(rv1), .res_ready(rr1), .res_data(rd1),
    .res_err(re1), .op_count(oc1)
  );

  // ---------------- dut3 (ALU_LAT=3) ----------------
  logic       cv3 = 1'b0, cr3, rv3, rr3 = 1'b1, re3;
  logic [1:0] cs3 = 2'd0, as3;
  logic [7:0] ca3 = 8'd0, cb3 = 8'd0, aa3, ab3;
  logic [15:0] z3, rd3, oc3, p1, p2;
  always @(posedge clk) begin
    p1 <= alu_f(aa3, ab3, as3);
    p2 <= p1;
  end
  assign z3 = p2;

  alu_op_sequencer #(.DW(8), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cv3), .cmd_ready(cr3), .cmd_sel(cs3),
    .cmd_a(ca3), .cmd_b(cb3), .alu_a(aa3), .alu_b(ab3), .alu_sel(as3),
    .alu_z(z3), .res_valid(rv3), .res_ready(rr3), .res_data(rd3),
    .res_err(re3), .op_count(oc3)
  );

  // ---------------- scoreboards ----------------
  logic [16:0] q1[$];
  logic [16:0] q3[$];

  always @(negedge clk) begin
    if (rst_n && rv1 && rr1) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_result", 32'(rd1), 32'h0);
        chk("dut1_result_queue_empty", 32'(q1.size()), 32'd1);
      end else begin
        logic [16:0] e;
        e = q1.pop_front();
        chk("dut1_res_data", 32'(rd1), 32'(e[15:0]));
        chk("dut1_res_err", 32'(re1), 32'(e[16]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && rv3 && rr3) begin
      if (q3.size() == 0) begin
        chk("dut3_result_queue_empty", 32'(q3.size()), 32'd1);
      end else begin
        logic [16:0] e;
        e = q3.pop_front();
        chk("dut3_res_data", 32'(rd3), 32'(e[15:0]));
        chk("dut3_res_err", 32'(re3), 32'(e[16]));
      end
    end
  end

  // Issue one command on dut1, called at a negedge. It checks the operand
  // registers, the edges from accept to res_valid, and waits for the handshake.
  task automatic cmd1(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s,
                      input logic [15:0] ed, input logic ee, input int el);
    int k;
    int n;
    k = 0;
    while (!cr1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("dut1_cmd_ready", 32'(cr1), 32'd1);
    ca1 = a; cb1 = b; cs1 = s; cv1 = 1'b1;
    q1.push_back({ee, ed});
    @(posedge clk); #1;
    cv1 = 1'b0;
    chk("dut1_alu_a", 32'(aa1), 32'(a));
    chk("dut1_alu_b", 32'(ab1), 32'(b));
    chk("dut1_alu_sel", 32'(as1), 32'(s));
    n = 0;
    while (!rv1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("dut1_latency", 32'(n), 32'(el));
    k = 0;
    while (rv1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("dut1_res_valid_fall", 32'(rv1), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    // -------- reset values --------
    repeat (3) @(negedge clk);
    chk("rst_res_valid", 32'(rv3), 32'd0);
    chk("rst_alu_a", 32'(aa3), 32'd0);
    chk("rst_res_data", 32'(rd3), 32'd0);
    chk("rst_res_err", 32'(re3), 32'd0);
    chk("rst_op_count", 32'(oc1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready1", 32'(cr1), 32'd1);
    chk("rst_cmd_ready3", 32'(cr3), 32'd1);

    // -------- asynchronous reset mid-WAIT on dut3 (command dropped) --------
    ca3 = 8'd7; cb3 = 8'd6; cs3 = 2'd1; cv3 = 1'b1;
    @(posedge clk); #1;
    cv3 = 1'b0;
    chk("midwait_alu_a", 32'(aa3), 32'd7);
    chk("midwait_in_wait", 32'(cr3), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_alu_a", 32'(aa3), 32'd0);
    chk("async_rst_alu_b", 32'(ab3), 32'd0);
    chk("async_rst_alu_sel", 32'(as3), 32'd0);
    chk("async_rst_res_valid", 32'(rv3), 32'd0);
    chk("async_rst_op_count", 32'(oc3), 32'd0);
    chk("async_rst_idle", 32'(cr3), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("dropped_no_result", 32'(rv3), 32'd0);
    chk("dropped_op_count", 32'(oc3), 32'd0);

    // -------- add, ALU_LAT=1 --------
    cmd1(8'd200, 8'd100, 2'd0, 16'd300, 1'b0, 1);
    chk("add_op_count", 32'(oc1), 32'd1);
    chk("add_cmd_ready", 32'(cr1), 32'd1);

    // -------- sub then mul back-to-back, second held off --------
    ca1 = 8'd3; cb1 = 8'd5; cs1 = 2'd1; cv1 = 1'b1;
    q1.push_back({1'b0, 16'hFFFE});
    @(posedge clk); #1;
    chk("b2b_alu_a_sub", 32'(aa1), 32'd3);
    ca1 = 8'd255; cb1 = 8'd255; cs1 = 2'd2;   // cv1 stays high
    q1.push_back({1'b0, 16'hFE01});
    @(posedge clk); #1;
    chk("b2b_resp_valid", 32'(rv1), 32'd1);
    chk("b2b_held_off", 32'(cr1), 32'd0);
    chk("b2b_alu_a_hold", 32'(aa1), 32'd3);
    @(posedge clk); #1;
    chk("b2b_idle_after_hs", 32'(cr1), 32'd1);
    chk("b2b_not_consumed", 32'(aa1), 32'd3);
    @(posedge clk); #1;
    cv1 = 1'b0;
    chk("b2b_alu_a_mul", 32'(aa1), 32'd255);
    chk("b2b_alu_sel_mul", 32'(as1), 32'd2);
    n = 0;
    while (!rv1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_mul_latency", 32'(n), 32'd1);
    @(posedge clk); #1;
    chk("b2b_op_count", 32'(oc1), 32'd3);
    @(negedge clk);

    // -------- divide-by-zero then normal divide --------
    cmd1(8'd9, 8'd0, 2'd3, 16'hFFFF, 1'b1, 0);
    cmd1(8'd9, 8'd2, 2'd3, 16'd4, 1'b0, 1);
    chk("div_op_count", 32'(oc1), 32'd5);

    // -------- backpressure on dut3 --------
    rr3 = 1'b0;
    ca3 = 8'd10; cb3 = 8'd3; cs3 = 2'd2; cv3 = 1'b1;
    q3.push_back({1'b0, 16'd30});
    @(posedge clk); #1;
    cv3 = 1'b0;
    chk("bp_alu_a", 32'(aa3), 32'd10);
    n = 0;
    while (!rv3 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_latency", 32'(n), 32'd3);
    ca3 = 8'd99; cb3 = 8'd1; cs3 = 2'd0; cv3 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid_hold", 32'(rv3), 32'd1);
      chk("bp_data_hold", 32'(rd3), 32'd30);
      chk("bp_cmd_ignored", 32'(aa3), 32'd10);
    end
    cv3 = 1'b0;
    rr3 = 1'b1;
    @(posedge clk); #1;
    chk("bp_valid_fall", 32'(rv3), 32'd0);
    chk("bp_op_count", 32'(oc3), 32'd1);
    @(posedge clk); #1;
    chk("bp_op_count_once", 32'(oc3), 32'd1);
    @(negedge clk);

    // -------- op_count wrap (preloaded to 16'hFFFF) --------
    force dut1.op_count_reg = 16'hFFFF;
    #1;
    release dut1.op_count_reg;
    chk("wrap_preload", 32'(oc1), 32'hFFFF);
    @(negedge clk);
    cmd1(8'd1, 8'd1, 2'd0, 16'd2, 1'b0, 1);
    chk("wrap_op_count", 32'(oc1), 32'd0);

    repeat (3) @(negedge clk);
    chk("dut1_queue_drained", 32'(q1.size()), 32'd0);
    chk("dut3_queue_drained", 32'(q3.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
